// File: rtl/echo_initiator_if.sv
// ============================================================================
// echo_initiator_if : MAC TX packet-buffer/doorbell and RX tap bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface echo_initiator_if #(
  parameter int ETH_MTU = 1518
);
  logic [7:0]  tx_pktbuf [ETH_MTU];
  logic [10:0] tx_pktbuf_maxaddr;
  logic        tx_doorbell;
  logic        tx_available;
  logic [7:0]  rx_pktbuf [ETH_MTU];
  logic [10:0] rx_pktbuf_maxaddr;
  logic        rx_doorbell;

  modport master (
    output tx_pktbuf, tx_pktbuf_maxaddr, tx_doorbell,
    input  tx_available, rx_pktbuf, rx_pktbuf_maxaddr, rx_doorbell
  );

  modport slave (
    input  tx_pktbuf, tx_pktbuf_maxaddr, tx_doorbell,
    output tx_available, rx_pktbuf, rx_pktbuf_maxaddr, rx_doorbell
  );
endinterface

`default_nettype wire

// File: rtl/echo_initiator.sv
// ============================================================================
// echo_initiator : sends an Ethertype echo request and verifies the reply
// Rev 1.0
// ============================================================================
`default_nettype none

module echo_initiator #(
  parameter int          ETH_MTU        = 1518,
  parameter int          PAYLOAD_LEN    = 46,
  parameter logic [47:0] MY_MAC         = 48'hb827eba43073,
  parameter logic [15:0] ECHO_ETYPE     = 16'h1234,
  parameter int          TIMEOUT_CYCLES = 5_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [47:0]       peer_mac,
  input  logic [7:0]        seed,
  echo_initiator_if.master  bus,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timed_out,
  output logic [7:0]        seq,
  output logic [15:0]       pass_count,
  output logic [15:0]       fail_count
);

  localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [10:0] MAXADDR  = 11'(13 + PAYLOAD_LEN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BUILD = 3'd1,
    S_PUSH  = 3'd2,
    S_WAIT  = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5,
    S_DRAIN = 3'd6
  } state_t;

  state_t        state, state_nx;
  logic [TW-1:0] timer;
  logic [47:0]   peer_q;
  logic [7:0]    seed_q;
  logic          rx_db_prev;
  logic          candidate;
  logic          payload_ok;

  // A reply is only a candidate on a fresh doorbell edge with swapped MACs.
  always_comb begin
    candidate = bus.rx_doorbell && !rx_db_prev &&
                ({bus.rx_pktbuf[12], bus.rx_pktbuf[13]} == ECHO_ETYPE);
    for (int i = 0; i < 6; i++) begin
      if (bus.rx_pktbuf[i] != MY_MAC[47-8*i -: 8])
        candidate = 1'b0;
      if (bus.rx_pktbuf[6+i] != peer_q[47-8*i -: 8])
        candidate = 1'b0;
    end
  end

  always_comb begin
    payload_ok = (bus.rx_pktbuf_maxaddr == bus.tx_pktbuf_maxaddr);
    for (int i = 0; i < PAYLOAD_LEN; i++) begin
      if (bus.rx_pktbuf[14+i] != bus.tx_pktbuf[14+i])
        payload_ok = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != S_IDLE);
    done     = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nx = S_BUILD;
      S_BUILD: state_nx = S_PUSH;
      S_PUSH:  if (bus.tx_available) state_nx = S_WAIT;
      S_WAIT: begin
        if (candidate)              state_nx = S_CHECK;
        else if (timer == TMO_LAST) state_nx = S_DONE;
      end
      S_CHECK: state_nx = S_DONE;
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_DRAIN;
      end
      S_DRAIN: if (!bus.rx_doorbell) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ETH_MTU; i++) bus.tx_pktbuf[i] <= 8'h00;
      bus.tx_pktbuf_maxaddr <= '0;
      bus.tx_doorbell       <= 1'b0;
      pass                  <= 1'b0;
      timed_out             <= 1'b0;
      seq                   <= '0;
      pass_count            <= '0;
      fail_count            <= '0;
      timer                 <= '0;
      peer_q                <= '0;
      seed_q                <= '0;
      rx_db_prev            <= 1'b0;
    end else begin
      rx_db_prev      <= bus.rx_doorbell;
      bus.tx_doorbell <= 1'b0;
      if (state == S_IDLE && start) begin
        peer_q <= peer_mac;
        seed_q <= seed;
      end
      if (state == S_BUILD) begin
        for (int i = 0; i < 6; i++) begin
          bus.tx_pktbuf[i]   <= peer_q[47-8*i -: 8];
          bus.tx_pktbuf[6+i] <= MY_MAC[47-8*i -: 8];
        end
        bus.tx_pktbuf[12] <= ECHO_ETYPE[15:8];
        bus.tx_pktbuf[13] <= ECHO_ETYPE[7:0];
        bus.tx_pktbuf[14] <= seq;
        for (int i = 1; i < PAYLOAD_LEN; i++)
          bus.tx_pktbuf[14+i] <= seed_q + seq + 8'(i);
        bus.tx_pktbuf_maxaddr <= MAXADDR;
      end
      if (state == S_PUSH && bus.tx_available) begin
        bus.tx_doorbell <= 1'b1;
        timer           <= '0;
      end
      if (state == S_WAIT)
        timer <= timer + TW'(1);
      // Results and statistics land together so they are valid while done is high.
      if (state_nx == S_DONE) begin
        pass      <= (state == S_CHECK) && payload_ok;
        timed_out <= (state == S_WAIT);
        seq       <= seq + 8'd1;
        if ((state == S_CHECK) && payload_ok) begin
          if (pass_count != 16'hFFFF) pass_count <= pass_count + 16'd1;
        end else begin
          if (fail_count != 16'hFFFF) fail_count <= fail_count + 16'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire
